// File: rtl/indication_arbiter.sv
// indication_arbiter: round-robin merge of NUM_REQ one-slot indication sources onto one tagged channel
module indication_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int SRC_W   = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        req__ENA,
    input  logic [NUM_REQ*DATA_W-1:0] req_v,
    output logic [NUM_REQ-1:0]        req__RDY,
    output logic                      out__ENA,
    output logic [DATA_W-1:0]         out_v,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out__RDY,
    input  logic                      arb_enable,
    output logic                      idle,
    output logic [31:0]               msg_count
);
    logic [NUM_REQ-1:0] full;
    logic [DATA_W-1:0]  data [NUM_REQ];
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   win;
    logic               any_full;
    logic               fire;

    assign any_full = |full;
    assign idle     = ~any_full;
    assign out__ENA = arb_enable & any_full;
    assign out_v    = out__ENA ? data[win] : '0;
    assign out_src  = out__ENA ? win : '0;
    assign fire     = out__ENA & out__RDY;

    // scan backwards from rr_ptr+NUM_REQ-1 so the last hit (closest to rr_ptr) wins
    always_comb begin
        logic [SRC_W-1:0] idx;
        idx = '0;
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k >= NUM_REQ) ? SRC_W'(int'(rr_ptr) + k - NUM_REQ) : SRC_W'(int'(rr_ptr) + k);
            if (full[idx]) win = idx;
        end
    end

    // a slot is ready when empty, or when it is being drained this very cycle
    always_comb begin
        req__RDY = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req__RDY[i] = ~full[i] | (fire & (win == SRC_W'(i)));
    end

    // slot occupancy, round-robin pointer and delivered-message counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            full      <= '0;
            rr_ptr    <= '0;
            msg_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (req__ENA[i] & req__RDY[i]) full[i] <= 1'b1;
                else if (fire && win == SRC_W'(i)) full[i] <= 1'b0;
            if (fire) begin
                rr_ptr    <= (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + SRC_W'(1);
                msg_count <= msg_count + 32'd1;
            end
        end
    end

    // payload capture; contents are meaningless while the slot is empty, so no reset
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_REQ; i++)
            if (req__ENA[i] & req__RDY[i]) data[i] <= req_v[i*DATA_W +: DATA_W];
    end
endmodule

// File: tb/tb_indication_arbiter.sv
// tb_indication_arbiter: directed checks of slot filling, round-robin order, backpressure, quiesce and reset
module tb_indication_arbiter;
    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [3:0]   req__ENA = '0;
    logic [127:0] req_v = '0;
    logic [3:0]   req__RDY;
    logic         out__ENA;
    logic [31:0]  out_v;
    logic [1:0]   out_src;
    logic         out__RDY = 1'b0;
    logic         arb_enable = 1'b0;
    logic         idle;
    logic [31:0]  msg_count;
    int           tests = 0;
    int           fails = 0;
    logic [31:0]  stored [4];

    indication_arbiter #(.NUM_REQ(4), .DATA_W(32), .SRC_W(2)) dut (
        .CLK(CLK), .RST(RST), .req__ENA(req__ENA), .req_v(req_v), .req__RDY(req__RDY),
        .out__ENA(out__ENA), .out_v(out_v), .out_src(out_src), .out__RDY(out__RDY),
        .arb_enable(arb_enable), .idle(idle), .msg_count(msg_count)
    );

    always #5 CLK = ~CLK;

    task automatic test_reset();
        RST = 1'b1; req__ENA = '0; out__RDY = 1'b0; arb_enable = 1'b1;
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0; #1;
        tests++; if (req__RDY !== 4'b1111) begin fails++; $display("FAIL reset_rdy got %b want 1111", req__RDY); end
        tests++; if (out__ENA !== 1'b0) begin fails++; $display("FAIL reset_ena got %b want 0", out__ENA); end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle got %b want 1", idle); end
        tests++; if (msg_count !== 32'd0) begin fails++; $display("FAIL reset_count got %0d want 0", msg_count); end
        tests++; if (out_v !== 32'd0 || out_src !== 2'd0) begin fails++; $display("FAIL reset_out got v=%h src=%0d want 0/0", out_v, out_src); end
    endtask

    task automatic test_single();
        req__ENA = 4'b0100; req_v = '0; req_v[95:64] = 32'hCAFE0002; out__RDY = 1'b1; arb_enable = 1'b1; #1;
        tests++; if (out__ENA !== 1'b0) begin fails++; $display("FAIL single_nobypass got %b want 0", out__ENA); end
        @(posedge CLK); #1;
        req__ENA = '0; #1;
        tests++; if (out__ENA !== 1'b1) begin fails++; $display("FAIL single_ena got %b want 1", out__ENA); end
        tests++; if (out_src !== 2'd2) begin fails++; $display("FAIL single_src got %0d want 2", out_src); end
        tests++; if (out_v !== 32'hCAFE0002) begin fails++; $display("FAIL single_v got %h want cafe0002", out_v); end
        tests++; if (req__RDY !== 4'b1111) begin fails++; $display("FAIL single_rdy got %b want 1111", req__RDY); end
        @(posedge CLK); #2;
        tests++; if (msg_count !== 32'd1) begin fails++; $display("FAIL single_count got %0d want 1", msg_count); end
        tests++; if (dut.rr_ptr !== 2'd3) begin fails++; $display("FAIL single_ptr got %0d want 3", dut.rr_ptr); end
        tests++; if (idle !== 1'b1 || out__ENA !== 1'b0) begin fails++; $display("FAIL single_drained got idle=%b ena=%b want 1/0", idle, out__ENA); end
    endtask

    task automatic test_fairness();
        int grants [4];
        int w;
        for (int i = 0; i < 4; i++) grants[i] = 0;
        for (int c = 0; c <= 12; c++) begin
            for (int i = 0; i < 4; i++) req_v[i*32 +: 32] = 32'hA0000000 | 32'(i << 16) | 32'(c);
            req__ENA = 4'hF; out__RDY = 1'b1; arb_enable = 1'b1; #1;
            if (c == 0) begin
                tests++; if (req__RDY !== 4'hF || out__ENA !== 1'b0) begin fails++; $display("FAIL fair_start got rdy=%b ena=%b want 1111/0", req__RDY, out__ENA); end
                for (int i = 0; i < 4; i++) stored[i] = 32'hA0000000 | 32'(i << 16);
            end else begin
                w = (c - 1) % 4;
                tests++; if (out__ENA !== 1'b1 || out_src !== 2'(w)) begin fails++; $display("FAIL fair_src c=%0d got ena=%b src=%0d want 1/%0d", c, out__ENA, out_src, w); end
                tests++; if (out_v !== stored[w]) begin fails++; $display("FAIL fair_v c=%0d got %h want %h", c, out_v, stored[w]); end
                tests++; if (req__RDY !== 4'(1 << w)) begin fails++; $display("FAIL fair_rdy c=%0d got %b want %b", c, req__RDY, 4'(1 << w)); end
                grants[out_src]++;
                stored[w] = 32'hA0000000 | 32'(w << 16) | 32'(c);
            end
            @(posedge CLK); #1;
        end
        req__ENA = '0; #1;
        tests++; if (msg_count !== 32'd12) begin fails++; $display("FAIL fair_count got %0d want 12", msg_count); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (grants[i] != 3) begin fails++; $display("FAIL fair_grants src=%0d got %0d want 3", i, grants[i]); end
        end
    endtask

    task automatic test_backpressure();
        out__RDY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin req__ENA = 4'b0010; req_v[63:32] = 32'hDEADBEEF; end
            else req__ENA = '0;
            #1;
            tests++; if (out__ENA !== 1'b1 || out_src !== 2'd0 || out_v !== stored[0]) begin fails++; $display("FAIL bp_hold k=%0d got ena=%b src=%0d v=%h want 1/0/%h", k, out__ENA, out_src, out_v, stored[0]); end
            tests++; if (req__RDY !== 4'b0000 || msg_count !== 32'd12) begin fails++; $display("FAIL bp_stall k=%0d got rdy=%b count=%0d want 0000/12", k, req__RDY, msg_count); end
            @(posedge CLK); #1;
        end
        req__ENA = '0; out__RDY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            tests++; if (out__ENA !== 1'b1 || out_src !== 2'(k) || out_v !== stored[k]) begin fails++; $display("FAIL bp_drain k=%0d got ena=%b src=%0d v=%h want 1/%0d/%h", k, out__ENA, out_src, out_v, k, stored[k]); end
            @(posedge CLK); #1;
        end
        #1;
        tests++; if (idle !== 1'b1 || out__ENA !== 1'b0 || msg_count !== 32'd16) begin fails++; $display("FAIL bp_done got idle=%b ena=%b count=%0d want 1/0/16", idle, out__ENA, msg_count); end
    endtask

    task automatic test_quiesce();
        arb_enable = 1'b0; out__RDY = 1'b1; req__ENA = 4'b1010;
        req_v[63:32] = 32'h11110001; req_v[127:96] = 32'h33330003; #1;
        tests++; if (req__RDY !== 4'b1111) begin fails++; $display("FAIL q_accept got %b want 1111", req__RDY); end
        @(posedge CLK); #1;
        req__ENA = '0; #1;
        tests++; if (out__ENA !== 1'b0 || idle !== 1'b0) begin fails++; $display("FAIL q_hold got ena=%b idle=%b want 0/0", out__ENA, idle); end
        tests++; if (req__RDY !== 4'b0101 || out_v !== 32'd0 || out_src !== 2'd0) begin fails++; $display("FAIL q_state got rdy=%b v=%h src=%0d want 0101/0/0", req__RDY, out_v, out_src); end
        @(posedge CLK); #2;
        tests++; if (out__ENA !== 1'b0 || msg_count !== 32'd16) begin fails++; $display("FAIL q_frozen got ena=%b count=%0d want 0/16", out__ENA, msg_count); end
        arb_enable = 1'b1; #1;
        tests++; if (out__ENA !== 1'b1 || out_src !== 2'd1 || out_v !== 32'h11110001) begin fails++; $display("FAIL q_first got ena=%b src=%0d v=%h want 1/1/11110001", out__ENA, out_src, out_v); end
        @(posedge CLK); #2;
        tests++; if (out__ENA !== 1'b1 || out_src !== 2'd3 || out_v !== 32'h33330003) begin fails++; $display("FAIL q_second got ena=%b src=%0d v=%h want 1/3/33330003", out__ENA, out_src, out_v); end
        @(posedge CLK); #2;
        tests++; if (idle !== 1'b1 || msg_count !== 32'd18) begin fails++; $display("FAIL q_done got idle=%b count=%0d want 1/18", idle, msg_count); end
    endtask

    task automatic test_reset_mid();
        out__RDY = 1'b0; arb_enable = 1'b1; req__ENA = 4'b0111;
        req_v = {32'h0, 32'h22220002, 32'h11110001, 32'h00000000};
        @(posedge CLK); #1;
        req__ENA = '0; #1;
        tests++; if (out__ENA !== 1'b1 || idle !== 1'b0 || out_src !== 2'd0) begin fails++; $display("FAIL mid_loaded got ena=%b idle=%b src=%0d want 1/0/0", out__ENA, idle, out_src); end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; out__RDY = 1'b1; #1;
        tests++; if (idle !== 1'b1 || out__ENA !== 1'b0 || msg_count !== 32'd0) begin fails++; $display("FAIL mid_reset got idle=%b ena=%b count=%0d want 1/0/0", idle, out__ENA, msg_count); end
        tests++; if (req__RDY !== 4'b1111) begin fails++; $display("FAIL mid_rdy got %b want 1111", req__RDY); end
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #2;
            tests++; if (out__ENA !== 1'b0 || msg_count !== 32'd0) begin fails++; $display("FAIL mid_stale k=%0d got ena=%b count=%0d want 0/0", k, out__ENA, msg_count); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset();
        test_fairness();
        test_backpressure();
        test_quiesce();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
